core_load_align_unit: RTL and testbench

- Sequential load unit for the data side of the core pipeline; a parametrised successor to the combinational writeback byte/half extraction.
- Accepts one load at a time from the memory stage and issues one or two aligned bus accesses; two are needed when the load crosses an XLEN/8-byte boundary.
- Merges the returned beats, sign- or zero-extends the result, and presents a one-cycle writeback pulse with the destination register.
- Supports XLEN 32 or 64 (LD/LWU in RV64) and an optional misaligned-load split mode.

---
 rtl/core_lsu_pkg.sv | 30 +++
 rtl/core_load_extract.sv | 47 ++++
 rtl/core_load_align_unit.sv | 164 ++++++++++++++++
 tb/tb_core_load_align_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_lsu_pkg.sv
// Shared types for the core load/store datapath: access sizes, load FSM states
// and the size-to-byte-count helper.
package core_lsu_pkg;

  typedef enum logic [1:0] {
    LD_B = 2'b00,
    LD_H = 2'b01,
    LD_W = 2'b10,
    LD_D = 2'b11
  } ld_size_e;

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    RSP0,
    REQ1,
    RSP1,
    WB
  } ld_state_e;

  function automatic logic [3:0] size_bytes(input ld_size_e size);
    case (size)
      LD_B:    return 4'd1;
      LD_H:    return 4'd2;
      LD_W:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/core_load_extract.sv
// Combinational merge of one or two bus beats into a load result:
// shift the selected bytes down, keep the access width, sign- or zero-extend.
module core_load_extract
  import core_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]             beat0,
  input  logic [XLEN-1:0]             beat1,
  input  logic [$clog2(XLEN/8)-1:0]   off,
  input  ld_size_e                    size,
  input  logic                        is_unsigned,
  output logic [XLEN-1:0]             data
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;
  logic            sign;

  // A word mask on a 32-bit datapath shifts everything out, leaving all-ones,
  // so a 32-bit word naturally passes through unextended.
  always_comb begin
    shifted = XLEN'({beat1, beat0} >> {off, 3'b000});
    mask    = '1;
    sign    = 1'b0;
    case (size)
      LD_B: begin
        mask = ~({XLEN{1'b1}} << 8);
        sign = shifted[7];
      end
      LD_H: begin
        mask = ~({XLEN{1'b1}} << 16);
        sign = shifted[15];
      end
      LD_W: begin
        mask = ~({XLEN{1'b1}} << 32);
        sign = shifted[31];
      end
      default: begin
        mask = '1;
        sign = shifted[XLEN-1];
      end
    endcase
    data = (shifted & mask) | ({XLEN{sign & ~is_unsigned}} & ~mask);
  end

endmodule

// File: rtl/core_load_align_unit.sv
// Sequential load unit: issues one or two aligned bus beats per load, merges and
// extends the result, and pulses writeback with the destination register.
module core_load_align_unit
  import core_lsu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int MISALIGN_EN = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [1:0]        ld_size_i,
  input  logic              ld_unsigned_i,
  input  logic [4:0]        ld_rd_i,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              wb_valid_o,
  output logic [4:0]        wb_rd_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic              misalign_err_o
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  ld_state_e         state;
  logic [OFF_W-1:0]  off_q;
  ld_size_e          size_q;
  logic              uns_q;
  logic [4:0]        rd_q;
  logic              split_q;
  logic              kill_q;
  logic              wb_valid_q;
  logic [XLEN-1:0]   beat0_q;

  logic [OFF_W-1:0]  ld_off;
  ld_size_e          ld_size;
  logic              ld_split;
  logic              ld_err;
  logic [ADDR_W-1:0] ld_aligned;
  logic              kill_now;
  logic [XLEN-1:0]   ex_beat0;
  logic [XLEN-1:0]   ex_beat1;
  logic [XLEN-1:0]   ex_data;

  assign ld_off     = ld_addr_i[OFF_W-1:0];
  assign ld_size    = ld_size_e'(ld_size_i);
  assign ld_split   = (int'(ld_off) + int'(size_bytes(ld_size))) > NB;
  assign ld_err     = (XLEN == 32 && ld_size == LD_D) || (ld_split && MISALIGN_EN == 0);
  assign ld_aligned = {ld_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign kill_now   = kill_q | flush_i;

  // The merge runs on the edge that captures the last beat, so the incoming
  // rdata feeds the extractor directly instead of being registered first.
  assign ex_beat0 = (state == RSP1) ? beat0_q : mem_rdata_i;
  assign ex_beat1 = (state == RSP1) ? mem_rdata_i : '0;

  core_load_extract #(.XLEN(XLEN)) u_extract (
    .beat0       (ex_beat0),
    .beat1       (ex_beat1),
    .off         (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (ex_data)
  );

  assign ld_ready_o = (state == IDLE);
  assign wb_valid_o = wb_valid_q & ~flush_i;

  // A killed load still finishes its bus handshakes so no response is left
  // outstanding; it only skips the second beat and the writeback.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      off_q          <= '0;
      size_q         <= LD_B;
      uns_q          <= 1'b0;
      rd_q           <= '0;
      split_q        <= 1'b0;
      kill_q         <= 1'b0;
      wb_valid_q     <= 1'b0;
      beat0_q        <= '0;
      mem_req_o      <= 1'b0;
      mem_addr_o     <= '0;
      wb_rd_o        <= '0;
      wb_data_o      <= '0;
      misalign_err_o <= 1'b0;
    end else begin
      misalign_err_o <= 1'b0;
      wb_valid_q     <= 1'b0;
      if (state != IDLE && flush_i) kill_q <= 1'b1;
      case (state)
        IDLE: begin
          if (ld_valid_i) begin
            if (ld_err) begin
              misalign_err_o <= 1'b1;
            end else begin
              state      <= REQ0;
              mem_req_o  <= 1'b1;
              mem_addr_o <= ld_aligned;
              off_q      <= ld_off;
              size_q     <= ld_size;
              uns_q      <= ld_unsigned_i;
              rd_q       <= ld_rd_i;
              split_q    <= ld_split;
              kill_q     <= flush_i;
            end
          end
        end
        REQ0: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state     <= RSP0;
          end
        end
        RSP0: begin
          if (mem_rvalid_i) begin
            beat0_q <= mem_rdata_i;
            if (kill_now) begin
              state <= IDLE;
            end else if (split_q) begin
              state      <= REQ1;
              mem_req_o  <= 1'b1;
              mem_addr_o <= mem_addr_o + ADDR_W'(NB);
            end else begin
              state      <= WB;
              wb_valid_q <= 1'b1;
              wb_data_o  <= ex_data;
              wb_rd_o    <= rd_q;
            end
          end
        end
        REQ1: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state     <= RSP1;
          end
        end
        RSP1: begin
          if (mem_rvalid_i) begin
            if (kill_now) begin
              state <= IDLE;
            end else begin
              state      <= WB;
              wb_valid_q <= 1'b1;
              wb_data_o  <= ex_data;
              wb_rd_o    <= rd_q;
            end
          end
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_load_align_unit.sv
// Directed bench for core_load_align_unit: three instances (32-bit split, 32-bit
// no-split, 64-bit) share the request/bus inputs and are exercised one at a time.
module tb_core_load_align_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v32, v32n, v64;
  logic [31:0] addr;
  logic [1:0]  size;
  logic        uns;
  logic [4:0]  rd;
  logic        flush, gnt, rvalid;
  logic [63:0] rdata;

  logic        rdy32, req32, wbv32, err32;
  logic [31:0] addr32, wbd32;
  logic [4:0]  wbrd32;
  logic        rdy32n, req32n, wbv32n, err32n;
  logic [31:0] addr32n, wbd32n;
  logic [4:0]  wbrd32n;
  logic        rdy64, req64, wbv64, err64;
  logic [31:0] addr64;
  logic [63:0] wbd64;
  logic [4:0]  wbrd64;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  core_load_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1)) u32 (
    .clk_i(clk), .rst_ni(rst_n), .ld_valid_i(v32), .ld_ready_o(rdy32),
    .ld_addr_i(addr), .ld_size_i(size), .ld_unsigned_i(uns), .ld_rd_i(rd),
    .flush_i(flush), .mem_req_o(req32), .mem_addr_o(addr32), .mem_gnt_i(gnt),
    .mem_rvalid_i(rvalid), .mem_rdata_i(rdata[31:0]), .wb_valid_o(wbv32),
    .wb_rd_o(wbrd32), .wb_data_o(wbd32), .misalign_err_o(err32)
  );

  core_load_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(0)) u32n (
    .clk_i(clk), .rst_ni(rst_n), .ld_valid_i(v32n), .ld_ready_o(rdy32n),
    .ld_addr_i(addr), .ld_size_i(size), .ld_unsigned_i(uns), .ld_rd_i(rd),
    .flush_i(flush), .mem_req_o(req32n), .mem_addr_o(addr32n), .mem_gnt_i(gnt),
    .mem_rvalid_i(rvalid), .mem_rdata_i(rdata[31:0]), .wb_valid_o(wbv32n),
    .wb_rd_o(wbrd32n), .wb_data_o(wbd32n), .misalign_err_o(err32n)
  );

  core_load_align_unit #(.XLEN(64), .ADDR_W(32), .MISALIGN_EN(1)) u64 (
    .clk_i(clk), .rst_ni(rst_n), .ld_valid_i(v64), .ld_ready_o(rdy64),
    .ld_addr_i(addr), .ld_size_i(size), .ld_unsigned_i(uns), .ld_rd_i(rd),
    .flush_i(flush), .mem_req_o(req64), .mem_addr_o(addr64), .mem_gnt_i(gnt),
    .mem_rvalid_i(rvalid), .mem_rdata_i(rdata), .wb_valid_o(wbv64),
    .wb_rd_o(wbrd64), .wb_data_o(wbd64), .misalign_err_o(err64)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one load to the selected instance for a single cycle; returns in
  // the cycle after acceptance.
  task automatic applyStimulus(input int unit, input logic [31:0] a, input logic [1:0] s,
                               input logic u, input logic [4:0] r);
    addr = a;
    size = s;
    uns  = u;
    rd   = r;
    v32  = (unit == 0);
    v32n = (unit == 1);
    v64  = (unit == 2);
    tick();
    v32  = 1'b0;
    v32n = 1'b0;
    v64  = 1'b0;
  endtask

  initial begin
    v32 = 0; v32n = 0; v64 = 0; addr = '0; size = '0; uns = 0; rd = '0;
    flush = 0; gnt = 0; rvalid = 0; rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready",   rdy32,  1);
    checkOutput("rst_req",     req32,  0);
    checkOutput("rst_addr",    addr32, 0);
    checkOutput("rst_wbv",     wbv32,  0);
    checkOutput("rst_wbrd",    wbrd32, 0);
    checkOutput("rst_wbdata",  wbd32,  0);
    checkOutput("rst_err",     err32,  0);
    checkOutput("rst_wbdata64", wbd64, 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] aligned signed half, XLEN=32");
    applyStimulus(0, 32'h1002, 2'b01, 1'b0, 5'd5);
    checkOutput("h_req",   req32,  1);
    checkOutput("h_addr",  addr32, 32'h1000);
    checkOutput("h_busy",  rdy32,  0);
    gnt = 1;
    tick();
    checkOutput("h_req_drop", req32, 0);
    gnt = 0; rvalid = 1; rdata = 64'h80FF_1234;
    tick();
    rvalid = 0;
    checkOutput("h_wbv",  wbv32,  1);
    checkOutput("h_data", wbd32,  32'hFFFF_80FF);
    checkOutput("h_rd",   wbrd32, 5);
    tick();
    checkOutput("h_wbv_pulse", wbv32, 0);
    checkOutput("h_idle",      rdy32, 1);

    $display("[TB] split word, XLEN=32");
    applyStimulus(0, 32'h1003, 2'b10, 1'b0, 5'd7);
    checkOutput("s_addr0", addr32, 32'h1000);
    gnt = 1;
    tick();
    gnt = 0; rvalid = 1; rdata = 64'hAABB_CCDD;
    tick();
    rvalid = 0;
    checkOutput("s_req1",  req32,  1);
    checkOutput("s_addr1", addr32, 32'h1004);
    checkOutput("s_nowb",  wbv32,  0);
    gnt = 1;
    tick();
    gnt = 0; rvalid = 1; rdata = 64'h1122_3344;
    tick();
    rvalid = 0;
    checkOutput("s_wbv",  wbv32,  1);
    checkOutput("s_data", wbd32,  32'h2233_44AA);
    checkOutput("s_rd",   wbrd32, 7);
    tick();

    $display("[TB] word loads, XLEN=64");
    for (int k = 0; k < 2; k++) begin
      applyStimulus(2, 32'h8, 2'b10, (k == 0), 5'd9);
      checkOutput("d_addr", addr64, 32'h8);
      gnt = 1;
      tick();
      gnt = 0; rvalid = 1; rdata = 64'h0000_0000_F000_0001;
      tick();
      rvalid = 0;
      checkOutput("d_wbv", wbv64, 1);
      checkOutput(k == 0 ? "d_word_uns" : "d_word_sgn", wbd64,
                  k == 0 ? 64'h0000_0000_F000_0001 : 64'hFFFF_FFFF_F000_0001);
      tick();
    end

    $display("[TB] last byte of a 64-bit beat");
    applyStimulus(2, 32'hF, 2'b00, 1'b0, 5'd2);
    checkOutput("b7_addr", addr64, 32'h8);
    checkOutput("b7_noerr", err64, 0);
    gnt = 1;
    tick();
    gnt = 0; rvalid = 1; rdata = 64'h8123_4567_89AB_CDEF;
    tick();
    rvalid = 0;
    checkOutput("b7_data", wbd64, 64'hFFFF_FFFF_FFFF_FF81);
    tick();

    $display("[TB] misalign disabled");
    applyStimulus(1, 32'h1001, 2'b10, 1'b0, 5'd4);
    checkOutput("me_err",   err32n, 1);
    checkOutput("me_noreq", req32n, 0);
    checkOutput("me_ready", rdy32n, 1);
    tick();
    checkOutput("me_err_pulse", err32n, 0);
    checkOutput("me_noreq2",    req32n, 0);
    applyStimulus(1, 32'h1002, 2'b01, 1'b0, 5'd4);
    checkOutput("fit_noerr", err32n, 0);
    checkOutput("fit_req",   req32n, 1);
    gnt = 1;
    tick();
    gnt = 0; rvalid = 1; rdata = 64'h1234_5678;
    tick();
    rvalid = 0;
    checkOutput("fit_data", wbd32n, 32'h0000_1234);
    tick();

    $display("[TB] double on 32-bit datapath");
    applyStimulus(0, 32'h1000, 2'b11, 1'b0, 5'd1);
    checkOutput("dd_err",   err32, 1);
    checkOutput("dd_noreq", req32, 0);
    tick();

    $display("[TB] flush in RSP0 of a split load");
    applyStimulus(0, 32'h1003, 2'b10, 1'b0, 5'd6);
    gnt = 1;
    tick();
    gnt = 0; flush = 1;
    tick();
    flush = 0;
    checkOutput("f_wait_busy", rdy32, 0);
    rvalid = 1; rdata = 64'h5555_5555;
    tick();
    rvalid = 0;
    checkOutput("f_no_beat1", req32, 0);
    checkOutput("f_no_wb",    wbv32, 0);
    checkOutput("f_idle",     rdy32, 1);
    tick();
    checkOutput("f_no_wb2",   wbv32, 0);

    $display("[TB] flush during writeback cycle");
    applyStimulus(0, 32'h1000, 2'b00, 1'b1, 5'd1);
    gnt = 1;
    tick();
    gnt = 0; rvalid = 1; rdata = 64'hA5;
    tick();
    rvalid = 0;
    flush = 1;
    #1;
    checkOutput("fwb_suppr", wbv32, 0);
    tick();
    flush = 0;
    checkOutput("fwb_idle", rdy32, 1);

    $display("[TB] withheld grant, then reset mid-load");
    applyStimulus(0, 32'h2000, 2'b10, 1'b0, 5'd3);
    for (int i = 0; i < 5; i++) begin
      checkOutput("g_req_hold",  req32,  1);
      checkOutput("g_addr_hold", addr32, 32'h2000);
      tick();
    end
    gnt = 1;
    tick();
    gnt = 0;
    checkOutput("g_rsp0", req32, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("r_req",   req32,  0);
    checkOutput("r_addr",  addr32, 0);
    checkOutput("r_ready", rdy32,  1);
    tick();
    rst_n = 1'b1;
    rvalid = 1; rdata = 64'hDEAD_BEEF;
    tick();
    rvalid = 0;
    checkOutput("r_stray_wb",  wbv32, 0);
    checkOutput("r_stray_req", req32, 0);
    tick();
    checkOutput("r_stray_wb2", wbv32, 0);
    checkOutput("r_idle",      rdy32, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
